pipelined_rca: RTL
==================

PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning operand/sum width in bits.
REQ-002 The block SHALL have parameter K, default 4, meaning bits per pipeline stage; N SHALL be an integer multiple of K, and S = N/K is the stage count.
REQ-003 The block SHALL have port clk  input  1  single clock; all registers rising-edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operand set present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-007 The block SHALL have ports x, y  input  N  operands, two's complement or unsigned.
REQ-008 The block SHALL have port c_in  input  1  carry/borrow in.
REQ-009 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 The block SHALL have ports s  output  N, c_out  output  1, overflow  output  1  result, carry out of bit N-1, signed overflow.

Function
REQ-013 Transfer SHALL occur on a rising edge where valid and ready are both 1, on each side independently.
REQ-014 Result SHALL be s = x + (y XOR {N{sub}}) + (c_in XOR sub), modulo 2^N; c_out SHALL be the raw carry out of bit N-1 (subtract: 1 = no borrow).
REQ-015 overflow SHALL be carry into bit N-1 XOR carry out of bit N-1, computed in the final stage.
REQ-016 Stage k (0..S-1) SHALL ripple bits [k*K+K-1 : k*K] using the registered carry from stage k-1 (stage 0 uses the effective carry in), registering its sum chunk, carry, and the untouched upper operand bits.
REQ-017 Lower sum chunks SHALL be carried forward so that s, c_out and overflow for one operand set appear together.
REQ-018 Each stage SHALL hold a valid bit; stage k SHALL load when stage k is empty or stage k advances in the same cycle.
REQ-019 in_ready SHALL equal NOT valid[0] OR advance[0]; it SHALL be combinational from out_ready through the stage chain.
REQ-020 Without stall, latency SHALL be exactly S cycles from accepting edge to out_valid = 1; throughput SHALL be one result per cycle.
REQ-021 With out_ready = 0 and out_valid = 1, s, c_out and overflow SHALL hold stable; bubbles SHALL compress until all S stages are full, then in_ready = 0.
REQ-022 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-023 Simultaneous accept and output transfer with a full pipeline SHALL be allowed with no bubble.
REQ-024 When S = 1, the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-025 On reset_n = 0, all stage valid bits SHALL clear immediately, so out_valid = 0 and in_ready = 1 after release.
REQ-026 On reset, s, c_out and overflow SHALL reset to 0, and all datapath registers SHALL reset to 0.
REQ-027 Operand sets in flight when reset asserts SHALL be discarded.

Configuration
REQ-028 When the macro PIPELINED_RCA_SAT_EN is defined, a result with overflow = 1 SHALL be clamped to 2^(N-1)-1 if x[N-1] = 0, else to -2^(N-1); overflow SHALL still read 1 and c_out SHALL be unchanged.
REQ-029 When PIPELINED_RCA_SAT_EN is undefined, s SHALL wrap modulo 2^N, with no extra logic.

Verification
REQ-030 N=16, K=4, no stall: x=0x1234, y=0x0FFF, c_in=0, sub=0 -> 4 cycles later s=0x2233, c_out=0, overflow=0.
REQ-031 Add x=0x7FFF, y=0x0001 -> s=0x8000 and overflow=1 (0x7FFF with SAT_EN); x=0xFFFF, y=0x0001 -> s=0x0000, c_out=1, overflow=0.
REQ-032 sub=1, c_in=0, x=0x0005, y=0x0007 -> s=0xFFFE, c_out=0; x=0x8000, y=0x0001 -> overflow=1, s=0x7FFF.
REQ-033 Continuous 100-set random stream with out_ready toggled randomly -> outputs match the reference model in order, no loss; in_ready=0 only when 4 stages are full and out_ready=0.
REQ-034 Assert reset_n=0 with 3 sets in flight -> out_valid=0 immediately; after release, the first new set emerges after 4 cycles with no stale data.

Source files
------------

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/sub: S = N/K stages of K bits each, latency S, one result per cycle.
// Stalls compress bubbles and in_ready drops only when every stage is full and blocked; PIPELINED_RCA_SAT_EN clamps on overflow.
module pipelined_rca #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow
);

  localparam int S = N / K;

  // Per-stage registers: operands travel with the partial sum so later stages see their chunk.
  logic [S-1:0] vld;
  logic [N-1:0] x_p [S];
  logic [N-1:0] y_p [S];
  logic [N-1:0] s_p [S];
  logic [S-1:0] c_p;
  logic         ov_q;

  logic [N-1:0] st_x [S];
  logic [N-1:0] st_y [S];
  logic [N-1:0] st_s [S];
  logic [N-1:0] nx_s [S];
  logic [S-1:0] st_c;
  logic [S-1:0] st_v;
  logic [S-1:0] nx_c;
  logic [S-1:0] load;
  logic [S-1:0] adv;
  logic         c_msb;
  logic         ov_nx;
  logic [N-1:0] fin_s;

  always_comb begin
    st_x[0] = x;
    st_y[0] = y ^ {N{sub}};
    st_s[0] = '0;
    st_c[0] = c_in ^ sub;
    st_v[0] = in_valid;
    for (int k = 1; k < S; k++) begin
      st_x[k] = x_p[k-1];
      st_y[k] = y_p[k-1];
      st_s[k] = s_p[k-1];
      st_c[k] = c_p[k-1];
      st_v[k] = vld[k-1];
    end
  end

  always_comb begin
    logic cy;
    int   bi;
    cy    = 1'b0;
    bi    = 0;
    c_msb = 1'b0;
    for (int k = 0; k < S; k++) begin
      nx_s[k] = st_s[k];
      cy      = st_c[k];
      for (int i = 0; i < K; i++) begin
        bi = k * K + i;
        nx_s[k][bi] = st_x[k][bi] ^ st_y[k][bi] ^ cy;
        if (bi == N - 1) c_msb = cy;
        cy = (st_x[k][bi] & st_y[k][bi]) | (cy & (st_x[k][bi] ^ st_y[k][bi]));
      end
      nx_c[k] = cy;
    end
  end

  always_comb begin
    ov_nx = c_msb ^ nx_c[S-1];
`ifdef PIPELINED_RCA_SAT_EN
    fin_s = nx_s[S-1];
    if (ov_nx) fin_s = st_x[S-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
    fin_s = nx_s[S-1];
`endif
  end

  // Ready ripples backwards from out_ready; a stage loads when empty or draining this cycle.
  always_comb begin
    logic r;
    r    = out_ready;
    load = '0;
    adv  = '0;
    for (int k = S - 1; k >= 0; k--) begin
      adv[k]  = vld[k] & r;
      load[k] = ~vld[k] | r;
      r       = load[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= '0;
      c_p  <= '0;
      ov_q <= 1'b0;
      for (int k = 0; k < S; k++) begin
        x_p[k] <= '0;
        y_p[k] <= '0;
        s_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load[k]) begin
          vld[k] <= st_v[k];
          if (st_v[k]) begin
            x_p[k] <= st_x[k];
            y_p[k] <= st_y[k];
            s_p[k] <= (k == S - 1) ? fin_s : nx_s[k];
            c_p[k] <= nx_c[k];
          end
        end
      end
      if (load[S-1] && st_v[S-1]) ov_q <= ov_nx;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld[S-1];
  assign s         = s_p[S-1];
  assign c_out     = c_p[S-1];
  assign overflow  = ov_q;

endmodule
